hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Consumes the per-instruction Tuse/Tnew/register-address decode of the D-stage instruction.
//  Tracks in-flight writers through E, M and W in internal shadow registers.
//  Produces the pipeline stall and the forwarding-mux selects for the 5-stage MIPS core.
//  Sits between the D-stage decoder and the datapath pipeline registers / forwarding MUXes.
// PARAMETERS
//  AW        5    register-address width
//  RES_NW    2'b00  Res code: no write
//  RES_ALU   2'b01  Res code: ALU result (Tnew E=1, M=0)
//  RES_DM    2'b10  Res code: DM/CP0 read (Tnew E=2, M=1)
//  RES_PC    2'b11  Res code: link PC+8 (Tnew 0 everywhere)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-low reset
//  tuse_rt    in   3   D instr: one-hot, rt needed at Tuse 0/1/2; 0 = unused
//  tuse_rs    in   2   D instr: one-hot, rs needed at Tuse 0/1; 0 = unused
//  res        in   2   D instr: result source code
//  a1_d       in   5   D instr rs address
//  a2_d       in   5   D instr rt address
//  a3_d       in   5   D instr destination address (0 = none)
//  d_is_md    in   1   D instr is mult/div/mthi/mtlo/mfhi/mflo
//  md_busy    in   1   multiply/divide unit busy (incl. start cycle)
//  flush      in   1   exception/eret: squash E, M, W tracking
//  stall      out  1   freeze PC + F/D reg, insert bubble into D/E
//  fwd_d_rs   out  2   D rs source: 0 RF, 1 E(PC+8), 2 M, 3 W
//  fwd_d_rt   out  2   D rt source: same encoding
//  fwd_e_rs   out  2   E rs source: 0 D/E reg, 2 M, 3 W (1 unused)
//  fwd_e_rt   out  2   E rt source: same encoding
//  fwd_m_rt   out  1   M store-data source: 0 E/M reg, 1 W
// BEHAVIOUR
//  - State: three stage records {a1,a2,a3,res} for E, M, W.
//  - All stage records reset to 0 / RES_NW while reset==0 at posedge.
//  - Every posedge, in priority order:
//      flush  -> all records cleared;
//      stall  -> E <= bubble(0), M <= E, W <= M;
//      else   -> E <= D inputs, M <= E, W <= M.
//  - Flush overrides stall in the same cycle.
//  - Tnew derivation:
//      E: ALU=1, DM=2, PC/NW=0.
//      M: DM=1, others 0.
//      W: always 0.
//  - match_X_rs = (a1_d==a3_X) & (a3_X!=0) & (res_X!=NW); rt analogous with a2_d.
//  - Stall when D needs rs/rt earlier than an in-flight writer provides it (Tuse<Tnew):
//      rs: tuse_rs[0]&(matchE&res_E in{ALU,DM} | matchM&res_M==DM)
//          | tuse_rs[1]&matchE&res_E==DM.
//      rt: same terms using tuse_rt[0]/[1]; tuse_rt[2] never stalls.
//  - md stall: d_is_md & md_busy.
//  - stall = OR of the rs, rt and md terms; purely combinational from current state + D inputs.
//  - stall is 0 during reset-low cycles, because all records read as NW.
//  - Forward select priority is nearest stage first.
//  - A stage is a valid forward source only when its value exists (Tnew==0 at that stage):
//      E source: res_E==PC.
//      M source: res_M in{ALU,PC}.
//      W source: any non-NW writer.
//  - Register $0 is never forwarded; select 0 then.
//  - fwd_e_* compare the E record a1/a2 against M/W; fwd_m_rt compares M.a2 against W.
//  - All fwd outputs are combinational and valid in the same cycle; no added latency.
// STRUCTURE
//  - Shared header constants:
//      Res codes RES_*, forward-select encodings FWD_RF/FWD_E/FWD_M/FWD_W.
//  - Sub-module hz_stage_reg: one {a1,a2,a3,res} record with clear/enable.
//      Instantiated x3 (E, M, W).
//  - Comparators and stall/forward logic live in the top module.
// TESTING
//  1 reset: hold reset=0 for 2 cycles, then release
//    -> stall=0 and all fwd_*=0 for the first cycle out of reset.
//  2 lw $8 then D beq $8,$9 (tuse_rs=01)
//    -> stall=1 for 2 cycles; then fwd_d_rs=3 and stall=0.
//  3 addu $8 then D beq $8
//    -> stall=1 for 1 cycle; then fwd_d_rs=2 (from M).
//  4 jal in E (a3=31, res=PC), D jr $31
//    -> stall=0 and fwd_d_rs=1.
//  5 D sw $8 (tuse_rt=100), lw $8 in E
//    -> no stall; two cycles later fwd_m_rt=1.
//  6 a3=0 writer (addu $0), D uses $0
//    -> stall=0 and fwd=0.
//  7 lw $8 in E, flush=1 together with a stall condition
//    -> next cycle all records NW, stall=0.
//  8 D mfhi with md_busy=1 for 5 cycles
//    -> stall=1 for exactly those 5 cycles, with an E bubble each cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, stage record type and Tnew helpers
// for the MIPS hazard controller.
package hazard_ctrl_pkg;

    localparam int AW = 5;

    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;
    localparam logic [1:0] RES_PC  = 2'b11;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] a3;
        logic [1:0]    res;
    } hz_rec_t;

    // cycles until the result exists, seen from E
    function automatic logic [1:0] tnew_e(input logic [1:0] r);
        logic [1:0] t;
        t = 2'd0;
        if (r == RES_ALU) t = 2'd1;
        if (r == RES_DM)  t = 2'd2;
        return t;
    endfunction

    // cycles until the result exists, seen from M
    function automatic logic [1:0] tnew_m(input logic [1:0] r);
        return (r == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // live writer of register a (never $0)
    function automatic logic hit(
        input logic [AW-1:0] a,
        input hz_rec_t       r
    );
        return (a == r.a3) && (r.a3 != '0) && (r.res != RES_NW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_stage_reg.sv
// One in-flight writer record {a1,a2,a3,res}
// with synchronous clear and enable.
import hazard_ctrl_pkg::*;

module hz_stage_reg (
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    en,
    input  hz_rec_t d,
    output hz_rec_t q
);

    // record register; clear loads an NW bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the 5-stage MIPS core,
// tracking writers in E, M and W.
import hazard_ctrl_pkg::*;

module hazard_ctrl (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    tuse_rt,
    input  logic [1:0]    tuse_rs,
    input  logic [1:0]    res,
    input  logic [AW-1:0] a1_d,
    input  logic [AW-1:0] a2_d,
    input  logic [AW-1:0] a3_d,
    input  logic          d_is_md,
    input  logic          md_busy,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic          fwd_m_rt
);

    hz_rec_t d_rec;
    hz_rec_t e_q;
    hz_rec_t m_q;
    hz_rec_t w_q;

    logic me_rs, mm_rs, mw_rs;
    logic me_rt, mm_rt, mw_rt;
    logic stall_rs, stall_rt, stall_md;

    // late when some needed Tuse level is below an in-flight Tnew
    function automatic logic late(
        input logic [2:0] tuse,
        input logic       he,
        input logic [1:0] tn_e,
        input logic       hm,
        input logic [1:0] tn_m
    );
        logic l;
        l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (tuse[i] && ((he && tn_e > 2'(i)) ||
                            (hm && tn_m > 2'(i))))
                l = 1'b1;
        end
        return l;
    endfunction

    // nearest stage whose value already exists wins
    function automatic logic [1:0] pick(
        input logic he,
        input logic hm,
        input logic hw
    );
        logic [1:0] s;
        s = FWD_RF;
        if (he)      s = FWD_E;
        else if (hm) s = FWD_M;
        else if (hw) s = FWD_W;
        return s;
    endfunction

    assign d_rec = '{a1: a1_d, a2: a2_d, a3: a3_d, res: res};

    hz_stage_reg u_e (
        .clk   (clk),
        .reset (reset),
        .clear (flush | stall),
        .en    (1'b1),
        .d     (d_rec),
        .q     (e_q)
    );

    hz_stage_reg u_m (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .en    (1'b1),
        .d     (e_q),
        .q     (m_q)
    );

    hz_stage_reg u_w (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .en    (1'b1),
        .d     (m_q),
        .q     (w_q)
    );

    // stall: D operand needed before its producer delivers it
    always_comb begin
        me_rs = hit(a1_d, e_q);
        mm_rs = hit(a1_d, m_q);
        mw_rs = hit(a1_d, w_q);
        me_rt = hit(a2_d, e_q);
        mm_rt = hit(a2_d, m_q);
        mw_rt = hit(a2_d, w_q);
        stall_rs = late({1'b0, tuse_rs},
                        me_rs, tnew_e(e_q.res),
                        mm_rs, tnew_m(m_q.res));
        stall_rt = late(tuse_rt,
                        me_rt, tnew_e(e_q.res),
                        mm_rt, tnew_m(m_q.res));
        stall_md = d_is_md & md_busy;
        stall    = stall_rs | stall_rt | stall_md;
    end

    // forwarding selects for D, E and M consumers
    always_comb begin
        fwd_d_rs = pick(me_rs && (e_q.res == RES_PC),
                        mm_rs && (tnew_m(m_q.res) == 2'd0),
                        mw_rs);
        fwd_d_rt = pick(me_rt && (e_q.res == RES_PC),
                        mm_rt && (tnew_m(m_q.res) == 2'd0),
                        mw_rt);
        fwd_e_rs = pick(1'b0,
                        hit(e_q.a1, m_q) &&
                        (tnew_m(m_q.res) == 2'd0),
                        hit(e_q.a1, w_q));
        fwd_e_rt = pick(1'b0,
                        hit(e_q.a2, m_q) &&
                        (tnew_m(m_q.res) == 2'd0),
                        hit(e_q.a2, w_q));
        fwd_m_rt = hit(m_q.a2, w_q);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl:
// stimulus queues expected outputs, monitor compares them.
import hazard_ctrl_pkg::*;

module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] tuse_rt;
    logic [1:0] tuse_rs;
    logic [1:0] res;
    logic [4:0] a1_d, a2_d, a3_d;
    logic       d_is_md, md_busy, flush;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic       fwd_m_rt;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_pass;

    hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .tuse_rt  (tuse_rt),
        .tuse_rs  (tuse_rs),
        .res      (res),
        .a1_d     (a1_d),
        .a2_d     (a2_d),
        .a3_d     (a3_d),
        .d_is_md  (d_is_md),
        .md_busy  (md_busy),
        .flush    (flush),
        .stall    (stall),
        .fwd_d_rs (fwd_d_rs),
        .fwd_d_rt (fwd_d_rt),
        .fwd_e_rs (fwd_e_rs),
        .fwd_e_rt (fwd_e_rt),
        .fwd_m_rt (fwd_m_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    // monitor: outputs are settled mid-cycle
    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {stall, fwd_d_rs, fwd_d_rt,
                   fwd_e_rs, fwd_e_rt, fwd_m_rt};
            n_chk++;
            if (act === e.v)
                n_pass++;
            else
                $display("FAIL %s: got %b want %b (stall,drs,drt,ers,ert,mrt)",
                         e.name, act, e.v);
        end
    end

    task automatic drv(
        input logic [2:0] trt,
        input logic [1:0] trs,
        input logic [1:0] r,
        input logic [4:0] x1,
        input logic [4:0] x2,
        input logic [4:0] x3,
        input logic       md,
        input logic       busy,
        input logic       fl
    );
        @(posedge clk);
        #1;
        tuse_rt = trt;
        tuse_rs = trs;
        res     = r;
        a1_d    = x1;
        a2_d    = x2;
        a3_d    = x3;
        d_is_md = md;
        md_busy = busy;
        flush   = fl;
    endtask

    task automatic chk(
        input string      nm,
        input logic       st,
        input logic [1:0] drs,
        input logic [1:0] drt,
        input logic [1:0] ers,
        input logic [1:0] ert,
        input logic       mrt
    );
        exp_t e;
        e.name = nm;
        e.v    = {st, drs, drt, ers, ert, mrt};
        sb.push_back(e);
    endtask

    task automatic nop();
        drv(3'b000, 2'b00, RES_NW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop3();
        repeat (3) nop();
    endtask

    task automatic lw8();
        drv(3'b000, 2'b10, RES_DM, 5'd29, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic beq89(input logic fl);
        drv(3'b001, 2'b01, RES_NW, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0, fl);
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        reset   = 1'b0;
        tuse_rt = '0;
        tuse_rs = '0;
        res     = RES_NW;
        a1_d    = '0;
        a2_d    = '0;
        a3_d    = '0;
        d_is_md = 1'b0;
        md_busy = 1'b0;
        flush   = 1'b0;

        // reset held two cycles, then released
        nop();
        chk("rst_hold0", 0, 0, 0, 0, 0, 0);
        nop();
        chk("rst_hold1", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_exit", 0, 0, 0, 0, 0, 0);
        nop3();

        // lw $8 then beq $8,$9
        lw8();
        chk("lw_issue", 0, 0, 0, 0, 0, 0);
        beq89(0);
        chk("lw_beq_st1", 1, 0, 0, 0, 0, 0);
        beq89(0);
        chk("lw_beq_st2", 1, 0, 0, 0, 0, 0);
        beq89(0);
        chk("lw_beq_fwdW", 0, 3, 0, 0, 0, 0);
        nop3();

        // addu $8 then beq $8,$9
        drv(3'b010, 2'b10, RES_ALU, 5'd10, 5'd11, 5'd8, 1'b0, 1'b0, 1'b0);
        chk("addu_issue", 0, 0, 0, 0, 0, 0);
        beq89(0);
        chk("alu_beq_st", 1, 0, 0, 0, 0, 0);
        beq89(0);
        chk("alu_beq_fwdM", 0, 2, 0, 0, 0, 0);
        nop3();

        // jal then jr $31
        drv(3'b000, 2'b00, RES_PC, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0);
        chk("jal_issue", 0, 0, 0, 0, 0, 0);
        drv(3'b000, 2'b01, RES_NW, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("jr_fwdE", 0, 1, 0, 0, 0, 0);
        nop();
        chk("jr_e_fwdM", 0, 0, 0, 2, 0, 0);
        nop();
        chk("jal_in_w", 0, 0, 0, 0, 0, 0);
        nop3();

        // lw $8 in E while sw $8 sits in D
        lw8();
        chk("lw_issue2", 0, 0, 0, 0, 0, 0);
        drv(3'b100, 2'b10, RES_NW, 5'd29, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("sw_nostall", 0, 0, 0, 0, 0, 0);
        nop();
        chk("sw_in_e", 0, 0, 0, 0, 0, 0);
        nop();
        chk("sw_fwdM_W", 0, 0, 0, 0, 0, 1);
        nop3();

        // writer to $0 never hazards
        drv(3'b010, 2'b10, RES_ALU, 5'd10, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("addu0_issue", 0, 0, 0, 0, 0, 0);
        drv(3'b001, 2'b01, RES_NW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("r0_e", 0, 0, 0, 0, 0, 0);
        drv(3'b001, 2'b01, RES_NW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("r0_m", 0, 0, 0, 0, 0, 0);
        nop3();

        // flush together with a load-use stall
        lw8();
        chk("lw_issue3", 0, 0, 0, 0, 0, 0);
        beq89(1);
        chk("flush_stall", 1, 0, 0, 0, 0, 0);
        beq89(0);
        chk("after_flush", 0, 0, 0, 0, 0, 0);
        nop3();

        // mfhi $8 while md unit busy for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drv(3'b000, 2'b00, RES_ALU, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
            chk($sformatf("md_busy%0d", i), 1, 0, 0, 0, 0, 0);
        end
        beq89(0);
        chk("md_bubble", 0, 0, 0, 0, 0, 0);
        drv(3'b000, 2'b00, RES_NW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("busy_not_md", 0, 0, 0, 0, 0, 0);

        nop();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
